pcpu_core: RTL and testbench
============================

# pcpu_core

Parametrised multicycle successor of the pcpu core: same 32-bit instruction word (low half opcode/register fields, high half immediate), generalised data width and register count, with an explicit memory request/ready handshake, condition flags, conditional jumps and a HALT state. Sits between the program ROM and the data memory arbiter in the SoC top.

## Interface
- DATA_W, 16: datapath, register, address and immediate-extended width; legal range 8..32.
- NREGS, 8: number of general registers; legal range 2..16, with register fields 4 bits wide. Fields indexing at or above NREGS read 0, and writes to them are dropped.
- RST_PC, 0: program counter value after reset.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- prog_addr  out  DATA_W  program counter.
- instr  in  32  instruction at prog_addr, valid combinationally in the same cycle.
- mem_addr  out  DATA_W  data address = rs1 + imm.
- mem_wdata  out  DATA_W  store data = rs2.
- mem_rdata  in  DATA_W  load data, sampled when mem_ready=1.
- mem_busy  in  1  arbiter busy; a new strobe is not raised while this is high.
- mem_ready  in  1  access complete, one-cycle pulse.
- ram_read, ram_write  out  1  access strobes.
- halted  out  1  core is in HALT.
- dbg_reg0  out  8  r0[7:0] for LEDs.
- irq  in  1  level interrupt request; present only with PCPU_IRQ_EN.

## Operation
- Decode fields:
  - op = instr[3:0]
  - rd/cond = instr[7:4]
  - rs1 = instr[11:8]
  - rs2 = instr[15:12]
  - imm = instr[31:16], sign-extended to DATA_W; when DATA_W<16, truncated.
- Opcodes:
  - 0 NOP
  - 1 MOV rd←imm
  - 2 ADD rd←rs1+rs2
  - 3 SUB rd←rs1−rs2
  - 4 AND
  - 5 OR
  - 6 XOR
  - 7 ADDI rd←rs1+imm
  - 8 LD rd←mem[rs1+imm]
  - 9 ST mem[rs1+imm]←rs2
  - A JMP cond → pc←imm
  - B JAL rd←pc+1, pc←rs1+imm
  - C HALT
  - D–F NOP
- Flags Z, C, N, V are updated only by ops 2–7.
  - C is the carry-out for ADD/ADDI and the borrow for SUB; it is 0 for logic ops.
  - V is 0 for logic ops.
- JMP conditions:
  - 0 always
  - 1 Z
  - 2 !Z
  - 3 C
  - 4 !C
  - 5 N
  - 6 V
  - 7 N!=V (signed less-than)
  - 8–F never
- Arithmetic wraps modulo 2^DATA_W. pc+1 wraps from all-ones to 0.
- FSM states:
  - EXEC:
    - Non-memory ops retire in one cycle.
    - LD/ST: if mem_busy=1, stay in EXEC with no strobe; otherwise go to MEM.
  - MEM:
    - Strobe held high, mem_addr and mem_wdata held stable.
    - On mem_ready=1: LD writes rd from mem_rdata, pc←pc+1, return to EXEC.
  - HALT: absorbing; only rst leaves it.
- A mem_ready pulse seen outside MEM is ignored.
- Reset values: prog_addr=RST_PC, all registers and flags 0, strobes 0, halted 0, state EXEC. rst during MEM drops the strobe in the same edge.

## Timing
- ALU, MOV, JMP, JAL, NOP: 1 cycle per instruction.
- LD/ST:
  - Strobe is high in the cycle after EXEC; the earliest retire is 2 cycles after issue.
  - One instruction per cycle overall, plus (busy cycles) plus (cycles waiting for ready).
- Strobes are low for at least 1 cycle between consecutive accesses.
- A register written by an instruction is visible to the next instruction; there is no hazard window.
- HALT: halted=1 from the cycle after decode; prog_addr stays frozen at the HALT address.

## Configuration
- PCPU_IRQ_EN defined:
  - irq is checked in EXEC before decode, when IE=1 and state≠MEM.
  - Taking an interrupt: EPC←pc, IE←0, pc←DATA_W'(4), 1 cycle.
  - Opcode D = RETI: pc←EPC, IE←1.
  - Opcode E = EI (IE←1); opcode F = DI (IE←0).
  - IE resets to 0. irq also wakes the core from HALT when IE=1.
- PCPU_IRQ_EN undefined: no irq port, no EPC or IE state, D–F are NOPs.

## Structure
- pcpu_pkg holds:
  - opcode localparams
  - JMP condition codes
  - FSM state enum
  - flag bit indices
  - IRQ vector constant
- One sub-module, pcpu_regfile (parameters DATA_W and NREGS): two combinational read ports and one synchronous write port, out-of-range indices handled as described under Interface.

## Test plan
- DATA_W=16: MOV r1,0x7FFF; ADDI r2,r1,1 → r2=0x8000, V=1, N=1, Z=0, C=0.
- SUB r3,r1,r1 followed by JMP cond=1 to 0x20 → prog_addr=0x20 on the next cycle; cond=2 at the same point falls through to pc+1.
- ST with mem_busy=1 for 3 cycles, then mem_ready 2 cycles after the strobe rises:
  - ram_write rises exactly once and stays high until ready.
  - mem_addr is stable throughout; retire happens 6 cycles after issue.
- LD with rst asserted while ram_read=1 → strobe 0 and prog_addr=RST_PC at the next edge; rd unchanged.
- DATA_W=32, NREGS=4: write to r5 is dropped and reading r5 returns 0; JMP from pc=0xFFFFFFFF with cond=8 wraps prog_addr to 0.
- PCPU_IRQ_EN: EI; HALT; irq=1 → prog_addr=4 and halted=0; RETI → prog_addr = HALT address + 1, IE=1.

Source files
------------

// File: rtl/pcpu_pkg.sv
// Shared opcodes, jump conditions, flag indices and FSM states for pcpu_core.
// The PCPU_IRQ_EN build also uses the RETI/EI/DI opcodes and the interrupt vector defined here.
package pcpu_pkg;

    localparam logic [3:0] OpNop  = 4'h0;
    localparam logic [3:0] OpMov  = 4'h1;
    localparam logic [3:0] OpAdd  = 4'h2;
    localparam logic [3:0] OpSub  = 4'h3;
    localparam logic [3:0] OpAnd  = 4'h4;
    localparam logic [3:0] OpOr   = 4'h5;
    localparam logic [3:0] OpXor  = 4'h6;
    localparam logic [3:0] OpAddi = 4'h7;
    localparam logic [3:0] OpLd   = 4'h8;
    localparam logic [3:0] OpSt   = 4'h9;
    localparam logic [3:0] OpJmp  = 4'hA;
    localparam logic [3:0] OpJal  = 4'hB;
    localparam logic [3:0] OpHalt = 4'hC;
    localparam logic [3:0] OpReti = 4'hD;
    localparam logic [3:0] OpEi   = 4'hE;
    localparam logic [3:0] OpDi   = 4'hF;

    localparam logic [3:0] CondAlways = 4'h0;
    localparam logic [3:0] CondZ      = 4'h1;
    localparam logic [3:0] CondNz     = 4'h2;
    localparam logic [3:0] CondC      = 4'h3;
    localparam logic [3:0] CondNc     = 4'h4;
    localparam logic [3:0] CondN      = 4'h5;
    localparam logic [3:0] CondV      = 4'h6;
    localparam logic [3:0] CondLt     = 4'h7;

    localparam int unsigned FlagZ = 0;
    localparam int unsigned FlagC = 1;
    localparam int unsigned FlagN = 2;
    localparam int unsigned FlagV = 3;

    localparam int unsigned IrqVector = 4;

    typedef enum logic [1:0] {StExec, StMem, StHalt} state_e;

    // Codes 8..F never match.
    function automatic logic cond_met(input logic [3:0] cond, input logic [3:0] flags);
        logic met;
        case (cond)
            CondAlways: met = 1'b1;
            CondZ:      met = flags[FlagZ];
            CondNz:     met = !flags[FlagZ];
            CondC:      met = flags[FlagC];
            CondNc:     met = !flags[FlagC];
            CondN:      met = flags[FlagN];
            CondV:      met = flags[FlagV];
            CondLt:     met = flags[FlagN] ^ flags[FlagV];
            default:    met = 1'b0;
        endcase
        return met;
    endfunction

endpackage

// File: rtl/pcpu_regfile.sv
// pcpu register file: two combinational read ports, one synchronous write port.
// Indices at or above NREGS read as zero and writes to them are dropped.
module pcpu_regfile #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NREGS  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [3:0]        raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    input  logic              we,
    input  logic [3:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] reg0
);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];

    always_comb begin
        regs_d  = regs_q;
        rdata_a = '0;
        rdata_b = '0;
        for (int i = 0; i < int'(NREGS); i++) begin
            if (we && waddr == 4'(i)) regs_d[i] = wdata;
            if (raddr_a == 4'(i)) rdata_a = regs_q[i];
            if (raddr_b == 4'(i)) rdata_b = regs_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    assign reg0 = regs_q[0];

endmodule

// File: rtl/pcpu_core.sv
// Parametrised multicycle pcpu core with memory handshake, flags, conditional jumps and HALT.
// Define PCPU_IRQ_EN to add the irq input, EPC/IE state and the RETI/EI/DI opcodes.
module pcpu_core
    import pcpu_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NREGS  = 8,
    parameter int unsigned RST_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [DATA_W-1:0] prog_addr,
    input  logic [31:0]       instr,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_busy,
    input  logic              mem_ready,
    output logic              ram_read,
    output logic              ram_write,
    output logic              halted,
    output logic [7:0]        dbg_reg0
`ifdef PCPU_IRQ_EN
    ,
    input  logic              irq
`endif
);

    localparam int unsigned Msb = DATA_W - 1;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [3:0]        flags_q, flags_d;
    logic [DATA_W-1:0] maddr_q, maddr_d;
    logic [DATA_W-1:0] mwdata_q, mwdata_d;
    logic [3:0]        mrd_q, mrd_d;
    logic              mld_q, mld_d;

    logic [3:0]        op, rd, rs1, rs2;
    logic [DATA_W-1:0] imm, a, rdata_b, alu_b, alu_res, pc_inc, reg0;
    logic [DATA_W:0]   sum, diff;
    logic              alu_c, alu_v, irq_take;
    logic              rf_we;
    logic [3:0]        rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    assign op     = instr[3:0];
    assign rd     = instr[7:4];
    assign rs1    = instr[11:8];
    assign rs2    = instr[15:12];
    assign imm    = DATA_W'($signed(instr[31:16]));
    assign pc_inc = pc_q + 1'b1;

    pcpu_regfile #(
        .DATA_W(DATA_W),
        .NREGS (NREGS)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .raddr_a(rs1),
        .rdata_a(a),
        .raddr_b(rs2),
        .rdata_b(rdata_b),
        .we     (rf_we),
        .waddr  (rf_waddr),
        .wdata  (rf_wdata),
        .reg0   (reg0)
    );

    // The adder also forms load/store addresses and the JAL target.
    assign alu_b = (op == OpAddi || op == OpLd || op == OpSt || op == OpJal) ? imm : rdata_b;
    assign sum   = {1'b0, a} + {1'b0, alu_b};
    assign diff  = {1'b0, a} - {1'b0, alu_b};

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op)
            OpAdd, OpAddi: begin
                {alu_c, alu_res} = sum;
                alu_v = (a[Msb] == alu_b[Msb]) && (sum[Msb] != a[Msb]);
            end
            OpSub: begin
                {alu_c, alu_res} = diff;
                alu_v = (a[Msb] != alu_b[Msb]) && (diff[Msb] != a[Msb]);
            end
            OpAnd:   alu_res = a & alu_b;
            OpOr:    alu_res = a | alu_b;
            OpXor:   alu_res = a ^ alu_b;
            default: ;
        endcase
    end

`ifdef PCPU_IRQ_EN
    logic              ie_q, ie_d;
    logic [DATA_W-1:0] epc_q, epc_d;
    assign irq_take = irq && ie_q;
`else
    assign irq_take = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        flags_d  = flags_q;
        maddr_d  = maddr_q;
        mwdata_d = mwdata_q;
        mrd_d    = mrd_q;
        mld_d    = mld_q;
        rf_we    = 1'b0;
        rf_waddr = rd;
        rf_wdata = alu_res;
`ifdef PCPU_IRQ_EN
        ie_d     = ie_q;
        epc_d    = epc_q;
`endif
        case (state_q)
            StExec: begin
                if (irq_take) begin
                    pc_d = DATA_W'(IrqVector);
`ifdef PCPU_IRQ_EN
                    epc_d = pc_q;
                    ie_d  = 1'b0;
`endif
                end else begin
                    pc_d = pc_inc;
                    case (op)
                        OpMov: begin
                            rf_we    = 1'b1;
                            rf_wdata = imm;
                        end
                        OpAdd, OpSub, OpAnd, OpOr, OpXor, OpAddi: begin
                            rf_we          = 1'b1;
                            flags_d[FlagZ] = (alu_res == '0);
                            flags_d[FlagC] = alu_c;
                            flags_d[FlagN] = alu_res[Msb];
                            flags_d[FlagV] = alu_v;
                        end
                        OpLd, OpSt: begin
                            pc_d = pc_q;
                            if (!mem_busy) begin
                                state_d  = StMem;
                                maddr_d  = sum[Msb:0];
                                mwdata_d = rdata_b;
                                mrd_d    = rd;
                                mld_d    = (op == OpLd);
                            end
                        end
                        OpJmp: if (cond_met(rd, flags_q)) pc_d = imm;
                        OpJal: begin
                            rf_we    = 1'b1;
                            rf_wdata = pc_inc;
                            pc_d     = sum[Msb:0];
                        end
                        OpHalt: begin
                            pc_d    = pc_q;
                            state_d = StHalt;
                        end
`ifdef PCPU_IRQ_EN
                        OpReti: begin
                            pc_d = epc_q;
                            ie_d = 1'b1;
                        end
                        OpEi: ie_d = 1'b1;
                        OpDi: ie_d = 1'b0;
`endif
                        default: ;
                    endcase
                end
            end
            StMem: begin
                if (mem_ready) begin
                    if (mld_q) begin
                        rf_we    = 1'b1;
                        rf_waddr = mrd_q;
                        rf_wdata = mem_rdata;
                    end
                    pc_d    = pc_inc;
                    state_d = StExec;
                end
            end
            StHalt: begin
                // Waking resumes after the HALT instruction on RETI.
                if (irq_take) begin
                    pc_d    = DATA_W'(IrqVector);
                    state_d = StExec;
`ifdef PCPU_IRQ_EN
                    epc_d = pc_inc;
                    ie_d  = 1'b0;
`endif
                end
            end
            default: state_d = StExec;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StExec;
            pc_q     <= DATA_W'(RST_PC);
            flags_q  <= '0;
            maddr_q  <= '0;
            mwdata_q <= '0;
            mrd_q    <= '0;
            mld_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            flags_q  <= flags_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
            mrd_q    <= mrd_d;
            mld_q    <= mld_d;
        end
    end

`ifdef PCPU_IRQ_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ie_q  <= 1'b0;
            epc_q <= '0;
        end else begin
            ie_q  <= ie_d;
            epc_q <= epc_d;
        end
    end
`endif

    assign prog_addr = pc_q;
    assign mem_addr  = maddr_q;
    assign mem_wdata = mwdata_q;
    assign ram_read  = (state_q == StMem) && mld_q;
    assign ram_write = (state_q == StMem) && !mld_q;
    assign halted    = (state_q == StHalt);
    assign dbg_reg0  = reg0[7:0];

endmodule

// File: tb/tb_pcpu_core.sv
// Directed bench for pcpu_core: a 16-bit/8-register core and a 32-bit/4-register core.
// The interrupt sequence is exercised only when PCPU_IRQ_EN is defined.
module tb_pcpu_core;

    logic        clk;
    logic        rst, rst32;
    logic [31:0] instr, instr32;
    logic [15:0] prog_addr, mem_addr, mem_wdata, mem_rdata;
    logic [31:0] prog_addr32, mem_addr32, mem_wdata32;
    logic        mem_busy, mem_ready;
    logic        ram_read, ram_write, halted;
    logic        ram_read32, ram_write32, halted32;
    logic [7:0]  dbg_reg0, dbg_reg032;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;

    pcpu_core #(.DATA_W(16), .NREGS(8), .RST_PC(0)) dut (
        .clk      (clk),
        .rst      (rst),
        .prog_addr(prog_addr),
        .instr    (instr),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_busy (mem_busy),
        .mem_ready(mem_ready),
        .ram_read (ram_read),
        .ram_write(ram_write),
        .halted   (halted),
        .dbg_reg0 (dbg_reg0)
`ifdef PCPU_IRQ_EN
        ,
        .irq      (irq)
`endif
    );

    pcpu_core #(.DATA_W(32), .NREGS(4), .RST_PC(0)) dut32 (
        .clk      (clk),
        .rst      (rst32),
        .prog_addr(prog_addr32),
        .instr    (instr32),
        .mem_addr (mem_addr32),
        .mem_wdata(mem_wdata32),
        .mem_rdata(32'h0),
        .mem_busy (1'b0),
        .mem_ready(1'b0),
        .ram_read (ram_read32),
        .ram_write(ram_write32),
        .halted   (halted32),
        .dbg_reg0 (dbg_reg032)
`ifdef PCPU_IRQ_EN
        ,
        .irq      (1'b0)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] enc(input logic [3:0] op, input logic [3:0] rd,
                                        input logic [3:0] rs1, input logic [3:0] rs2,
                                        input logic [15:0] imm);
        return {imm, rs2, rs1, rd, op};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exec(input logic [31:0] w);
        instr = w;
        step();
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [15:0] exp_pc;

    initial begin
        rst = 1'b1; rst32 = 1'b1; instr = '0; instr32 = '0;
        mem_rdata = '0; mem_busy = 1'b0; mem_ready = 1'b0; irq = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("reset_pc", 32'(prog_addr), 32'h0);
        chk("reset_strobes", {30'b0, ram_read, ram_write}, 32'h0);
        chk("reset_halted", 32'(halted), 32'h0);
        chk("reset_r0", 32'(dbg_reg0), 32'h0);

        // Overflow into the sign bit, observed through conditional jumps.
        exec(enc(4'h1, 4'd1, 4'd0, 4'd0, 16'h7FFF));
        exec(enc(4'h7, 4'd2, 4'd1, 4'd0, 16'h0001));
        chk("mov_addi_pc", 32'(prog_addr), 32'h2);
        exec(enc(4'hA, 4'd6, 4'd0, 4'd0, 16'h0010));
        chk("jmp_v_taken", 32'(prog_addr), 32'h10);
        exec(enc(4'hA, 4'd5, 4'd0, 4'd0, 16'h0018));
        chk("jmp_n_taken", 32'(prog_addr), 32'h18);
        exec(enc(4'hA, 4'd1, 4'd0, 4'd0, 16'h0030));
        chk("jmp_z_not", 32'(prog_addr), 32'h19);
        exec(enc(4'hA, 4'd3, 4'd0, 4'd0, 16'h0030));
        chk("jmp_c_not", 32'(prog_addr), 32'h1A);
        exec(enc(4'hA, 4'd7, 4'd0, 4'd0, 16'h0030));
        chk("jmp_lt_not", 32'(prog_addr), 32'h1B);

        // ST r2 -> [r0+5]: confirms r2 = 0x8000.
        exec(enc(4'h9, 4'd0, 4'd0, 4'd2, 16'h0005));
        chk("st_strobe", {30'b0, ram_read, ram_write}, 32'h1);
        chk("st_addr", 32'(mem_addr), 32'h5);
        chk("st_wdata_r2", 32'(mem_wdata), 32'h8000);
        chk("st_pc_hold", 32'(prog_addr), 32'h1B);
        mem_ready = 1'b1;
        exec(enc(4'h0, 4'd0, 4'd0, 4'd0, 16'h0));
        mem_ready = 1'b0;
        chk("st_retire_strobe", {30'b0, ram_read, ram_write}, 32'h0);
        chk("st_retire_pc", 32'(prog_addr), 32'h1C);

        exec(enc(4'h3, 4'd3, 4'd1, 4'd1, 16'h0));
        exec(enc(4'hA, 4'd1, 4'd0, 4'd0, 16'h0020));
        chk("sub_z_jmp", 32'(prog_addr), 32'h20);
        exec(enc(4'hA, 4'd2, 4'd0, 4'd0, 16'h0040));
        chk("sub_nz_fall", 32'(prog_addr), 32'h21);

        exec(enc(4'h1, 4'd4, 4'd0, 4'd0, 16'h00F0));
        exec(enc(4'h6, 4'd0, 4'd1, 4'd4, 16'h0));
        chk("xor_r0", 32'(dbg_reg0), 32'h0F);
        exec(enc(4'h4, 4'd0, 4'd1, 4'd4, 16'h0));
        chk("and_r0", 32'(dbg_reg0), 32'hF0);
        // 0x8000 + 0x8000: carry and overflow set.
        exec(enc(4'h2, 4'd5, 4'd2, 4'd2, 16'h0));
        exec(enc(4'hA, 4'd3, 4'd0, 4'd0, 16'h0050));
        chk("add_c_taken", 32'(prog_addr), 32'h50);
        exec(enc(4'hA, 4'd6, 4'd0, 4'd0, 16'h0060));
        chk("add_v_taken", 32'(prog_addr), 32'h60);
        exec(enc(4'h5, 4'd0, 4'd4, 4'd4, 16'h0));
        chk("or_r0", 32'(dbg_reg0), 32'hF0);
        exec(enc(4'hA, 4'd3, 4'd0, 4'd0, 16'h0070));
        chk("logic_c_clear", 32'(prog_addr), 32'h62);
        exec(enc(4'hA, 4'd4, 4'd0, 4'd0, 16'h0070));
        chk("logic_nc_taken", 32'(prog_addr), 32'h70);

        // ST r4 -> [r1+1] with 3 busy cycles then ready in the second strobe cycle.
        instr = enc(4'h9, 4'd0, 4'd1, 4'd4, 16'h0001);
        mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("busy_no_strobe", {30'b0, ram_read, ram_write}, 32'h0);
            chk("busy_pc_hold", 32'(prog_addr), 32'h70);
        end
        mem_busy = 1'b0;
        step();
        chk("st2_strobe_rise", 32'(ram_write), 32'h1);
        chk("st2_addr", 32'(mem_addr), 32'h8000);
        chk("st2_wdata", 32'(mem_wdata), 32'h00F0);
        instr = '0;
        mem_busy = 1'b1;
        step();
        mem_busy = 1'b0;
        chk("st2_strobe_held", 32'(ram_write), 32'h1);
        chk("st2_addr_stable", 32'(mem_addr), 32'h8000);
        chk("st2_pc_hold", 32'(prog_addr), 32'h70);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        chk("st2_strobe_fall", 32'(ram_write), 32'h0);
        chk("st2_retire_6", 32'(prog_addr), 32'h71);

        // LD r0 <- [r3+0x10]; ready while still busy in EXEC is ignored.
        mem_busy = 1'b1; mem_ready = 1'b1; mem_rdata = 16'h1234;
        exec(enc(4'h8, 4'd0, 4'd3, 4'd0, 16'h0010));
        chk("ld_ready_ignored_pc", 32'(prog_addr), 32'h71);
        chk("ld_ready_ignored_r0", 32'(dbg_reg0), 32'hF0);
        mem_busy = 1'b0; mem_ready = 1'b0;
        step();
        chk("ld_strobe", {30'b0, ram_read, ram_write}, 32'h2);
        chk("ld_addr", 32'(mem_addr), 32'h10);
        mem_ready = 1'b1; mem_rdata = 16'h00A5;
        exec('0);
        mem_ready = 1'b0;
        chk("ld_r0", 32'(dbg_reg0), 32'hA5);
        chk("ld_retire_pc", 32'(prog_addr), 32'h72);
        chk("ld_strobe_fall", 32'(ram_read), 32'h0);

        // JAL r6, r1, 1: pc <- 0x8000, r6 <- 0x73.
        exec(enc(4'hB, 4'd6, 4'd1, 4'd0, 16'h0001));
        chk("jal_pc", 32'(prog_addr), 32'h8000);
        exec(enc(4'h9, 4'd0, 4'd0, 4'd6, 16'h0000));
        chk("jal_link", 32'(mem_wdata), 32'h73);
        mem_ready = 1'b1;
        exec('0);
        mem_ready = 1'b0;
        exp_pc = 16'h8001;
        chk("jal_st_retire", 32'(prog_addr), 32'(exp_pc));

        // Reset while a load strobe is up.
        exec(enc(4'h8, 4'd0, 4'd0, 4'd0, 16'h0));
        chk("ld_rst_strobe_up", 32'(ram_read), 32'h1);
        rst = 1'b1; mem_ready = 1'b1; mem_rdata = 16'h0077;
        step();
        rst = 1'b0; mem_ready = 1'b0;
        chk("ld_rst_strobe", 32'(ram_read), 32'h0);
        chk("ld_rst_pc", 32'(prog_addr), 32'h0);
        chk("ld_rst_r0", 32'(dbg_reg0), 32'h0);

        exec(enc(4'h0, 4'd0, 4'd0, 4'd0, 16'h0));
        exec(enc(4'hC, 4'd0, 4'd0, 4'd0, 16'h0));
        chk("halt_flag", 32'(halted), 32'h1);
        chk("halt_pc", 32'(prog_addr), 32'h1);
        mem_ready = 1'b1;
        exec(enc(4'h1, 4'd0, 4'd0, 4'd0, 16'h00AA));
        mem_ready = 1'b0;
        chk("halt_absorb_pc", 32'(prog_addr), 32'h1);
        chk("halt_absorb_r0", 32'(dbg_reg0), 32'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("halt_rst", {31'b0, halted}, 32'h0);

`ifdef PCPU_IRQ_EN
        exec(enc(4'hE, 4'd0, 4'd0, 4'd0, 16'h0));
        exec(enc(4'hC, 4'd0, 4'd0, 4'd0, 16'h0));
        chk("irq_halt_pc", 32'(prog_addr), 32'h1);
        irq = 1'b1;
        exec('0);
        irq = 1'b0;
        chk("irq_wake_pc", 32'(prog_addr), 32'h4);
        chk("irq_wake_halted", 32'(halted), 32'h0);
        exec(enc(4'hD, 4'd0, 4'd0, 4'd0, 16'h0));
        chk("reti_pc", 32'(prog_addr), 32'h2);
        irq = 1'b1;
        exec(enc(4'hC, 4'd0, 4'd0, 4'd0, 16'h0));
        irq = 1'b0;
        chk("reti_ie_set", 32'(prog_addr), 32'h4);
        chk("irq_preempts_halt", 32'(halted), 32'h0);
        exec(enc(4'hF, 4'd0, 4'd0, 4'd0, 16'h0));
        irq = 1'b1;
        exec('0);
        irq = 1'b0;
        chk("di_masks_irq", 32'(prog_addr), 32'h6);
`endif

        // 32-bit, 4-register core.
        rst32 = 1'b0;
        chk("w32_reset_pc", prog_addr32, 32'h0);
        instr32 = enc(4'h1, 4'd0, 4'd0, 4'd0, 16'h0055);
        step();
        chk("w32_mov_r0", 32'(dbg_reg032), 32'h55);
        instr32 = enc(4'h1, 4'd5, 4'd0, 4'd0, 16'h0007);
        step();
        instr32 = enc(4'h2, 4'd0, 4'd5, 4'd5, 16'h0);
        step();
        chk("w32_r5_reads_0", 32'(dbg_reg032), 32'h0);
        instr32 = enc(4'hA, 4'd0, 4'd0, 4'd0, 16'hFFFF);
        step();
        chk("w32_jmp_sext", prog_addr32, 32'hFFFF_FFFF);
        instr32 = enc(4'hA, 4'd8, 4'd0, 4'd0, 16'h0010);
        step();
        chk("w32_pc_wrap", prog_addr32, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
